// File: rtl/key_extract_param_if.sv
// AXI-Stream bundle for the control path.
interface key_extract_param_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast);
  modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/key_extract_param.sv
// Key extractor for one match-action stage: two-cycle PHV pipeline that
// gathers selected containers plus a comparator bit into a lookup key, with
// offset/mask tables programmed in-band over the control stream.
module key_extract_param #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned STAGE_ID             = 0,
  parameter int unsigned NUM_CONT             = 8,
  parameter int unsigned KEY_SEL              = 2,
  parameter int unsigned META_W               = 356,
  parameter int unsigned PHV_LEN              = 96*NUM_CONT+META_W,
  parameter int unsigned KEY_LEN              = 96*KEY_SEL+1,
  parameter int unsigned KEY_OFF              = 3*KEY_SEL*$clog2(NUM_CONT)+2*$clog2(NUM_CONT)+2,
  parameter int unsigned KEY_OFF_ADDR_WIDTH   = 4,
  parameter int unsigned IDX_LSB              = 129,
  parameter int unsigned KEY_EX_ID            = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PHV_LEN-1:0]  phv_in,
  input  logic                phv_valid_in,
  output logic [PHV_LEN-1:0]  phv_out,
  output logic                phv_valid_out,
  output logic [KEY_LEN-1:0]  key_out,
  output logic                key_valid_out,
  output logic [KEY_LEN-1:0]  key_mask_out,
  key_extract_param_if.slave  c_s_axis,
  key_extract_param_if.master c_m_axis
);

  localparam int unsigned CW       = $clog2(NUM_CONT);
  localparam int unsigned AW       = KEY_OFF_ADDR_WIDTH;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned DW       = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned UW       = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned KW       = C_S_AXIS_DATA_WIDTH/8;
  localparam int unsigned OFF_CMPA = 3*KEY_SEL*CW;
  localparam int unsigned OFF_CMPB = OFF_CMPA + CW;
  localparam int unsigned OFF_OP   = OFF_CMPB + CW;
  localparam int unsigned C4_BASE  = META_W + 16*NUM_CONT;
  localparam int unsigned C6_BASE  = META_W + 48*NUM_CONT;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_WR, ST_DROP} ctl_state_e;

  // lookup tables
  logic [KEY_OFF-1:0] off_tbl_q  [DEPTH];
  logic [KEY_OFF-1:0] off_tbl_d  [DEPTH];
  logic [KEY_LEN-1:0] mask_tbl_q [DEPTH];
  logic [KEY_LEN-1:0] mask_tbl_d [DEPTH];

  // stage 1
  logic [AW-1:0]      idx_c;
  logic [PHV_LEN-1:0] phv_s1_q, phv_s1_d;
  logic               vld_s1_q, vld_s1_d;
  logic [KEY_OFF-1:0] off_s1_q, off_s1_d;
  logic [KEY_LEN-1:0] mask_s1_q, mask_s1_d;

  // stage 2
  logic [15:0]        cmp_a_c, cmp_b_c;
  logic               cmp_c;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic               vld_out_q, vld_out_d;
  logic [KEY_LEN-1:0] key_q, key_d;
  logic [KEY_LEN-1:0] mask_out_q, mask_out_d;

  // control path
  ctl_state_e         state_q, state_d;
  logic [3:0]         type_q, type_d;
  logic [AW-1:0]      cidx_q, cidx_d;
  logic [7:0]         hdr_mod_c;
  logic               fwd_c;
  logic [DW-1:0]      m_tdata_q, m_tdata_d;
  logic [UW-1:0]      m_tuser_q, m_tuser_d;
  logic [KW-1:0]      m_tkeep_q, m_tkeep_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;

  assign idx_c     = phv_in[IDX_LSB +: AW];
  assign hdr_mod_c = c_s_axis.tdata[112 +: 8];

  // Stage 1: capture the PHV and read both tables at its index
  always_comb begin
    phv_s1_d  = phv_in;
    vld_s1_d  = phv_valid_in;
    off_s1_d  = off_tbl_q[idx_c];
    mask_s1_d = mask_tbl_q[idx_c];
  end

  // Comparator over two 2B containers chosen by the entry
  always_comb begin
    cmp_a_c = phv_s1_q[META_W + 16*32'(off_s1_q[OFF_CMPA +: CW]) +: 16];
    cmp_b_c = phv_s1_q[META_W + 16*32'(off_s1_q[OFF_CMPB +: CW]) +: 16];
    cmp_c   = 1'b0;
    case (off_s1_q[OFF_OP +: 2])
      2'b01:   cmp_c = cmp_a_c >  cmp_b_c;
      2'b10:   cmp_c = cmp_a_c >= cmp_b_c;
      2'b11:   cmp_c = cmp_a_c == cmp_b_c;
      default: cmp_c = 1'b0;
    endcase
  end

  // Stage 2: key assembly, first selection lands in the more significant slot
  always_comb begin
    key_d = '0;
    for (int unsigned i = 0; i < KEY_SEL; i++) begin
      key_d[1 + 16*(KEY_SEL-1-i) +: 16] =
        phv_s1_q[META_W + 16*32'(off_s1_q[i*CW +: CW]) +: 16];
      key_d[1 + 16*KEY_SEL + 32*(KEY_SEL-1-i) +: 32] =
        phv_s1_q[C4_BASE + 32*32'(off_s1_q[(KEY_SEL+i)*CW +: CW]) +: 32];
      key_d[1 + 48*KEY_SEL + 48*(KEY_SEL-1-i) +: 48] =
        phv_s1_q[C6_BASE + 48*32'(off_s1_q[(2*KEY_SEL+i)*CW +: CW]) +: 48];
    end
    key_d[0]   = cmp_c;
    phv_out_d  = phv_s1_q;
    vld_out_d  = vld_s1_q;
    mask_out_d = mask_s1_q;
  end

  // Control FSM: decode headers, write tables, forward foreign packets
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    cidx_d     = cidx_q;
    off_tbl_d  = off_tbl_q;
    mask_tbl_d = mask_tbl_q;
    fwd_c      = 1'b0;
    if (c_s_axis.tvalid) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_mod_c == 8'(KEY_EX_ID)) begin
            type_d = c_s_axis.tdata[124 +: 4];
            cidx_d = c_s_axis.tdata[128 +: AW];
            if (!c_s_axis.tlast) state_d = ST_WR;
          end else begin
            fwd_c = 1'b1;
            if (!c_s_axis.tlast) state_d = ST_FWD;
          end
        end
        ST_FWD: begin
          fwd_c = 1'b1;
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
        ST_WR: begin
          if (type_q == 4'd1) off_tbl_d[cidx_q]  = c_s_axis.tdata[KEY_OFF-1:0];
          if (type_q == 4'd2) mask_tbl_d[cidx_q] = c_s_axis.tdata[KEY_LEN-1:0];
          state_d = c_s_axis.tlast ? ST_IDLE : ST_DROP;
        end
        default: begin
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
      endcase
    end
    m_tvalid_d = fwd_c;
    m_tdata_d  = fwd_c ? c_s_axis.tdata : m_tdata_q;
    m_tuser_d  = fwd_c ? c_s_axis.tuser : m_tuser_q;
    m_tkeep_d  = fwd_c ? c_s_axis.tkeep : m_tkeep_q;
    m_tlast_d  = fwd_c ? c_s_axis.tlast : 1'b0;
  end

  // State, pipeline and forwarding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_s1_q   <= '0;
      vld_s1_q   <= 1'b0;
      off_s1_q   <= '0;
      mask_s1_q  <= '0;
      phv_out_q  <= '0;
      vld_out_q  <= 1'b0;
      key_q      <= '0;
      mask_out_q <= '0;
      state_q    <= ST_IDLE;
      type_q     <= '0;
      cidx_q     <= '0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      phv_s1_q   <= phv_s1_d;
      vld_s1_q   <= vld_s1_d;
      off_s1_q   <= off_s1_d;
      mask_s1_q  <= mask_s1_d;
      phv_out_q  <= phv_out_d;
      vld_out_q  <= vld_out_d;
      key_q      <= key_d;
      mask_out_q <= mask_out_d;
      state_q    <= state_d;
      type_q     <= type_d;
      cidx_q     <= cidx_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  // Table storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        off_tbl_q[i]  <= '0;
        mask_tbl_q[i] <= '0;
      end
    end else begin
      off_tbl_q  <= off_tbl_d;
      mask_tbl_q <= mask_tbl_d;
    end
  end

  assign phv_out          = phv_out_q;
  assign phv_valid_out    = vld_out_q;
  assign key_out          = key_q;
  assign key_valid_out    = vld_out_q;
  assign key_mask_out     = mask_out_q;
  assign c_m_axis.tdata   = m_tdata_q;
  assign c_m_axis.tuser   = m_tuser_q;
  assign c_m_axis.tkeep   = m_tkeep_q;
  assign c_m_axis.tvalid  = m_tvalid_q;
  assign c_m_axis.tlast   = m_tlast_q;

endmodule

// File: doc/key_extract_param.md
Name: key_extract_param

Overview:
- Parametrised key extractor for one RMT match-action stage.
- Each PHV selects a per-flow entry from an offset table and a mask table.
- Gathers KEY_SEL containers of each width class (6B/4B/2B) plus one programmable comparator bit into a lookup key, and emits the entry's key mask alongside it.
- Tables are written in-band over the AXIS control path; control packets addressed to other modules pass through.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, control AXIS data width.
- C_S_AXIS_TUSER_WIDTH, 128, control AXIS tuser width.
- STAGE_ID, 0, stage number; informational only.
- NUM_CONT, 8, containers per width class (power of 2, ≥2); CW = clog2(NUM_CONT).
- KEY_SEL, 2, containers selected per width class.
- META_W, 356, metadata bits below the containers in the PHV.
- PHV_LEN, 96*NUM_CONT+META_W, PHV width.
- KEY_LEN, 96*KEY_SEL+1, key width.
- KEY_OFF, 3*KEY_SEL*CW+2*CW+2, offset entry width.
- KEY_OFF_ADDR_WIDTH, 4, table depth 2^KEY_OFF_ADDR_WIDTH.
- IDX_LSB, 129, PHV bit position of the table index field.
- KEY_EX_ID, 1, module ID this block answers to on the control path.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- phv_in in PHV_LEN: input PHV.
- phv_valid_in in 1: PHV valid.
- phv_out out PHV_LEN: PHV delayed by 2 cycles.
- phv_valid_out out 1: PHV valid, delayed by 2 cycles.
- key_out out KEY_LEN: extracted key.
- key_valid_out out 1: key valid (equals phv_valid_out).
- key_mask_out out KEY_LEN: mask entry for this PHV.
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast in 256/128/32/1/1: control slave.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast out 256/128/32/1/1: control master.

Behaviour:
- PHV layout:
  - 2B container i = phv[META_W+16i +:16].
  - 4B container i = phv[META_W+16N+32i +:32].
  - 6B container i = phv[META_W+48N+48i +:48].
- Table index: idx = phv_in[IDX_LSB +: KEY_OFF_ADDR_WIDTH].
- Offset entry, LSB first:
  - 2B sel[0..KS-1], then 4B sel[0..KS-1], then 6B sel[0..KS-1], each CW bits.
  - cmpA (CW), cmpB (CW), op (2 bits).
- Comparator:
  - a = 2B[cmpA], b = 2B[cmpB], compared unsigned.
  - op 00 gives 0; op 01 gives a>b; op 10 gives a>=b; op 11 gives a==b.
- Key layout, MSB to LSB: 6B[sel0..selKS-1], 4B[sel0..], 2B[sel0..], cmp.
- Pipeline, no backpressure, one PHV accepted every cycle:
  - Stage 1 registers the PHV and reads both tables at idx.
  - Stage 2 muxes the containers, computes the comparator bit, and registers all outputs.
  - Latency is exactly 2 cycles for phv_out, key_out and key_mask_out.
- Reset values:
  - All outputs 0; both valids 0.
  - Offset table all 0, so the key selects container 0 everywhere and cmp = 0.
  - Mask table all 0.
  - Control FSM in IDLE.
- Control FSM (state changes only on c_s_axis_tvalid beats):
  - IDLE: every beat is a header beat.
    - mod = tdata[112+:8], type = tdata[124+:4], cidx = tdata[128+:8].
    - If mod==KEY_EX_ID, go to WR (a header beat with tlast also set stays in IDLE and writes nothing).
    - Otherwise forward the beat and go to FWD if !tlast.
  - FWD: forward every beat; return to IDLE on tlast.
  - WR: the next beat is the data beat.
    - type 1 writes offset[cidx] = tdata[KEY_OFF-1:0].
    - type 2 writes mask[cidx] = tdata[KEY_LEN-1:0].
    - Any other type writes nothing.
    - Go to IDLE if tlast, else DROP.
  - DROP: discard beats until tlast, then go to IDLE.
  - Matched packets are never forwarded.
- Forwarding adds 1-cycle registered latency and all fields pass unchanged; c_m_axis_tvalid is 0 when nothing is forwarded.
- Index bounds: cidx bits at or above KEY_OFF_ADDR_WIDTH are ignored, so the address wraps modulo depth.
- A table write and a PHV lookup of the same index in the same cycle: the lookup gets the old entry. The write is visible to PHVs accepted from the next cycle on.
- Reset mid-packet returns the FSM to IDLE and clears the pipeline valids; the next beat is treated as a header.
- tkeep/tuser are ignored for decoding.

Test Plan:
- Post-reset PHV, valid 1 cycle, 6B[0]=0xAAAAAAAAAAAA → 2 cycles later key top 48b = 0xAAAAAAAAAAAA, cmp=0, mask=0, phv_out==phv_in.
- Control packet: mod=1, type=1, cidx=3, data selecting 6B{7,6}, 4B{7,6}, 2B{7,6}, cmpA=7, cmpB=6, op=01. Then PHV with idx=3, 6B7=0xFFFFFFFFFFFF, 6B6=0xEEEEEEEEEEEE, 4B7=0xCCCCCCCC, 4B6=0xBBBBBBBB, 2B7=0xFFFF, 2B6=0xEEEE. Expected key = {FFFFFFFFFFFF, EEEEEEEEEEEE, CCCCCCCC, BBBBBBBB, FFFF, EEEE, 1}.
- Same entry with op=11 and 2B7==2B6=0x1234 → cmp=1; op=00 → cmp=0.
- Mask write: mod=1, type=2, cidx=3, data all ones → key_mask_out all ones for idx=3, zero for idx=4.
- Control packet mod=2, 4 beats → emerges on c_m_axis unchanged, 1-cycle delayed, tlast on beat 4; tables unchanged.
- Write to cidx=5 in the same cycle as a PHV with idx=5 → that PHV gets the old key; a PHV on the next cycle gets the new key.
- Back-to-back PHVs on consecutive cycles → outputs on consecutive cycles, none dropped.
